// File: rtl/dmem_lsu_if.sv
// Core-side request/response handshake plus the word-wide data-memory port.
// slave = the load/store unit, master = the core/memory side driving it.
interface dmem_lsu_if;
  localparam int WORD_LEN = 32;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  logic                resp_valid;
  logic [WORD_LEN-1:0] resp_rdata;
  logic                resp_err;
  logic [WORD_LEN-1:0] addr_d;
  logic [WORD_LEN-1:0] rdata;
  logic                wen;
  logic [WORD_LEN-1:0] wdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, addr_d, wen, wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, addr_d, wen, wdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: turns byte/half/word core requests into word accesses,
// doing read-modify-write for sub-word stores on a word-write-only memory.
module dmem_lsu (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus
);
  localparam int WORD_LEN = 32;

  typedef enum logic [2:0] {IDLE, RD, EXT, WR, ACK} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          f3_reg, f3_next;
  logic [1:0]          off_reg, off_next;
  logic                we_reg, we_next;
  logic                err_reg, err_next;
  logic [WORD_LEN-1:0] sdata_reg, sdata_next;
  logic [WORD_LEN-1:0] addr_d_reg, addr_d_next;
  logic [WORD_LEN-1:0] wdata_reg, wdata_next;
  logic [WORD_LEN-1:0] rdata_reg, rdata_next;

  logic                req_err;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [WORD_LEN-1:0] load_val;
  logic [WORD_LEN-1:0] merged;

  // Misalignment and illegal funct3 are both reported as a single error.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  assign ld_byte = bus.rdata[{off_reg, 3'b000} +: 8];
  assign ld_half = off_reg[1] ? bus.rdata[31:16] : bus.rdata[15:0];

  always_comb begin
    load_val = bus.rdata;
    case (f3_reg)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'h0, ld_byte};
      3'b101:  load_val = {16'h0, ld_half};
      default: load_val = bus.rdata;
    endcase
  end

  // Byte-lane merge for SB/SH: each lane takes store data or keeps memory data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_src;
      assign lane_hit = (f3_reg[1:0] == 2'b00) ? (off_reg == LANE)
                                               : (off_reg[1] == LANE[1]);
      assign lane_src = (f3_reg[1:0] == 2'b00) ? sdata_reg[7:0]
                                               : sdata_reg[8*(gi%2) +: 8];
      assign merged[8*gi +: 8] = lane_hit ? lane_src : bus.rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    f3_next     = f3_reg;
    off_next    = off_reg;
    we_next     = we_reg;
    err_next    = err_reg;
    sdata_next  = sdata_reg;
    addr_d_next = addr_d_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          f3_next     = bus.req_funct3;
          off_next    = bus.req_addr[1:0];
          we_next     = bus.req_we;
          err_next    = req_err;
          sdata_next  = bus.req_wdata;
          addr_d_next = {bus.req_addr[WORD_LEN-1:2], 2'b00};
          rdata_next  = '0;
          if (req_err) begin
            state_next = ACK;
          end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
            wdata_next = bus.req_wdata;
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:  state_next = EXT;
      EXT: begin
        if (we_reg) begin
          wdata_next = merged;
          state_next = WR;
        end else begin
          rdata_next = load_val;
          state_next = ACK;
        end
      end
      WR:      state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      f3_reg     <= '0;
      off_reg    <= '0;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      sdata_reg  <= '0;
      addr_d_reg <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      f3_reg     <= f3_next;
      off_reg    <= off_next;
      we_reg     <= we_next;
      err_reg    <= err_next;
      sdata_reg  <= sdata_next;
      addr_d_reg <= addr_d_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == ACK);
  assign bus.resp_err   = err_reg;
  assign bus.resp_rdata = rdata_reg;
  assign bus.addr_d     = addr_d_reg;
  assign bus.wdata      = wdata_reg;
  // Gating with rst keeps a reset that lands mid-RMW from corrupting memory.
  assign bus.wen        = (state_reg == WR) && !rst;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word memory model and a response scoreboard.
module tb_dmem_lsu;
  logic clk;
  logic rst;
  dmem_lsu_if bus ();

  dmem_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 1-cycle registered read, word write, plus a backdoor preload.
  logic [31:0] mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    bus.rdata <= mem[bus.addr_d[9:2]];
    if (bus.wen) mem[bus.addr_d[9:2]] <= bus.wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = addr[9:2]; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_wen_cyc, input logic [31:0] exp_wen_data);
    exp_t e;
    int waitc, lat, wen_cnt, wen_cyc;
    logic [31:0] wen_d, wen_a;
    bit got;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb_q.push_back(e);
    lat = 0; wen_cnt = 0; wen_cyc = 0; wen_d = '0; wen_a = '0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (bus.wen) begin wen_cnt++; wen_cyc = lat; wen_d = bus.wdata; wen_a = bus.addr_d; end
      if (bus.resp_valid) got = 1;
    end
    check({tag, " resp seen"}, 32'(got), 32'd1);
    if (got) begin
      e = sb_q.pop_front();
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
      check({tag, " rdata"}, bus.resp_rdata, e.rdata);
      check({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
      check({tag, " ready in ack"}, 32'(bus.req_ready), 32'd0);
      check({tag, " addr_d"}, bus.addr_d, {addr[31:2], 2'b00});
    end
    if (exp_wen_cyc == 0) begin
      check({tag, " wen count"}, 32'(wen_cnt), 32'd0);
    end else begin
      check({tag, " wen count"}, 32'(wen_cnt), 32'd1);
      check({tag, " wen cycle"}, 32'(wen_cyc), 32'(exp_wen_cyc));
      check({tag, " wen data"}, wen_d, exp_wen_data);
      check({tag, " wen addr"}, wen_a, {addr[31:2], 2'b00});
    end
  endtask

  initial begin
    exp_t e;
    logic seen_wr_wen;
    rst = 1'b1;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wen during reset", 32'(bus.wen), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_err", 32'(bus.resp_err), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'h0);
    check("reset addr_d", bus.addr_d, 32'h0);
    check("reset wdata", bus.wdata, 32'h0);

    // Loads from a preloaded word
    preload(32'h100, 32'h8899AABB);
    do_req("LB 0x101",  1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0, 32'h0);
    do_req("LBU 0x103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 3, 0, 32'h0);
    do_req("LHU 0x102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 3, 0, 32'h0);
    do_req("LH 0x100",  1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFAABB, 1'b0, 3, 0, 32'h0);

    // Stores: RMW byte, full word, RMW halfword
    do_req("SB 0x102",  1'b1, 3'b000, 32'h102, 32'h12345655, 32'h0, 1'b0, 4, 3, 32'h8855AABB);
    do_req("LW 0x100",  1'b0, 3'b010, 32'h100, 32'h0, 32'h8855AABB, 1'b0, 3, 0, 32'h0);
    do_req("SW 0x104",  1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF);
    do_req("LW 0x104",  1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 32'h0);
    do_req("SH 0x106",  1'b1, 3'b001, 32'h106, 32'h0000CAFE, 32'h0, 1'b0, 4, 3, 32'hCAFEBEEF);
    do_req("LW 0x104b", 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEBEEF, 1'b0, 3, 0, 32'h0);

    // Misaligned and illegal requests
    do_req("SH 0x101 err",  1'b1, 3'b001, 32'h101, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0);
    do_req("LW 0x102 err",  1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    do_req("LD f3=011 err", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    do_req("ST f3=100 err", 1'b1, 3'b100, 32'h104, 32'h11111111, 32'h0, 1'b1, 1, 0, 32'h0);
    check("mem 0x100 after errors", mem[8'h40], 32'h8855AABB);
    check("mem 0x104 after errors", mem[8'h41], 32'hCAFEBEEF);

    // Reset during the WR cycle of an SB must suppress the write
    preload(32'h100, 32'h8899AABB);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h00000077;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    seen_wr_wen = bus.wen;
    check("rmw reached WR", 32'(seen_wr_wen), 32'd1);
    rst = 1'b1;
    #1;
    check("wen gated by rst", 32'(bus.wen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset ready", 32'(bus.req_ready), 32'd1);
    check("post-reset resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    check("post-reset ready+1", 32'(bus.req_ready), 32'd1);
    check("post-reset resp_valid+1", 32'(bus.resp_valid), 32'd0);
    check("mem 0x100 after reset", mem[8'h40], 32'h8899AABB);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h0;
    e.rdata = 32'h8899AABB; e.err = 1'b0; e.lat = 3;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.req_addr = 32'h104;
    e.rdata = 32'hCAFEBEEF; e.err = 1'b0; e.lat = 7;
    sb_q.push_back(e);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("b2b ready c%0d", c), 32'(bus.req_ready), 32'((c == 4) || (c == 8)));
      check($sformatf("b2b resp_valid c%0d", c), 32'(bus.resp_valid), 32'((c == 3) || (c == 7)));
      if (bus.resp_valid && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("b2b resp cycle c%0d", c), 32'(c), 32'(e.lat));
        check($sformatf("b2b rdata c%0d", c), bus.resp_rdata, e.rdata);
        check($sformatf("b2b err c%0d", c), 32'(bus.resp_err), 32'(e.err));
      end
      if (c == 4) begin
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
      end
    end
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that initiates accesses on the data-memory port (addr_d/rdata/wen/wdata) of the shared instruction/data memory.
- Converts a core-side byte/halfword/word load or store request into word-granular memory transactions.
- The memory port has word-only write enable and a 1-cycle registered read, so sub-word stores are done as read-modify-write (RMW).
- Sits between the core execute/memory stage and the memory block; one outstanding request at a time.

Parameters:
- WORD_LEN, 32, data/address width (from consts.vh; not overridable locally)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  LSU can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse, no backpressure
- resp_rdata  output  32  load result, extended; 0 for stores and errors
- resp_err  output  1  misaligned or illegal funct3; valid with resp_valid
- addr_d  output  32  memory data address, registered
- rdata  input  32  memory read data; reflects addr_d one edge after it is presented
- wen  output  1  memory word write enable
- wdata  output  32  memory write word

Behaviour:
- Reset:
  - Clock and reset are decided: one clock clk; rst synchronous, active-high.
  - When rst is sampled high: state <= IDLE; resp_valid, resp_err, resp_rdata, addr_d, wdata all <= 0.
  - wen is gated by !rst, so no memory write occurs at an edge where rst is high, including mid-RMW.
- States: IDLE, RD, EXT, WR, ACK.
- IDLE:
  - req_ready = 1; the request is accepted at an edge with req_valid high.
  - Latch funct3, addr[1:0] and wdata; addr_d <= {req_addr[31:2], 2'b00}.
  - On error, go to ACK with err = 1; memory is never touched.
  - Error conditions:
    - LH, LHU or SH with addr[0] = 1.
    - LW or SW with addr[1:0] != 0.
    - Load funct3 in {011, 110, 111}.
    - Store funct3 not in {000, 001, 010}.
  - Valid load, SB or SH: go to RD.
  - Valid SW: go to WR with wdata <= req_wdata.
- RD: wait state; memory samples addr_d at the end of this cycle. -> EXT.
- EXT: rdata is valid this cycle.
  - Load:
    - Select the byte at addr[1:0] or the halfword at addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
    - resp_rdata <= result; -> ACK.
  - SB/SH:
    - wdata <= rdata with the selected lane replaced by req_wdata[7:0] or [15:0].
    - -> WR.
- WR:
  - wen = 1 (combinational from state, gated by !rst); the memory writes wdata at the end of this cycle.
  - -> ACK.
- ACK:
  - resp_valid = 1 for exactly one cycle.
  - resp_err is as latched.
  - resp_rdata is 0 unless the request was a successful load.
  - -> IDLE.
- wen is high only in WR. addr_d holds its value from accept until the next accept.
- Latency, accept edge to resp_valid cycle:
  - Load: 3 edges (RD, EXT, ACK).
  - SW: 2 edges.
  - SB/SH: 4 edges.
  - Error: 1 edge.
- Back-to-back: the next request can be accepted in the cycle after ACK (IDLE). req_ready is low in ACK.
- req_valid while not ready is ignored; the core must hold it.

Test Plan:
- Preload word 0x100 = 0x8899AABB; LB 0x101 -> resp_valid 3 cycles after accept, resp_rdata 0xFFFFFFAA, err 0; LBU 0x103 -> 0x00000088; LHU 0x102 -> 0x00008899; LH 0x100 -> 0xFFFFAABB.
- SB 0x102, wdata 0x12345655 -> exactly one wen pulse with wdata 0x8855AABB at addr_d 0x100; ack 4 cycles after accept; following LW 0x100 -> 0x8855AABB.
- SW 0x104 = 0xDEADBEEF -> wen 1 cycle after accept, ack 2 cycles after accept; LW 0x104 -> 0xDEADBEEF; SH 0x106 = 0x0000CAFE then LW -> 0xCAFEBEEF.
- Misaligned and illegal: SH 0x101, LW 0x102, load funct3 011 -> resp_valid next cycle, resp_err 1, resp_rdata 0, wen never asserted, memory unchanged.
- Reset mid-RMW: SB 0x100, assert rst during the WR cycle -> no write (word still 0x8899AABB), resp_valid 0, req_ready 1 the cycle after reset deasserts.
- Back-to-back: req_valid held high for LW 0x100 then LW 0x104 -> second accept in the cycle after the first ACK; req_ready low in RD/EXT/ACK.
